sum_accumulator: RTL

SUM_ACCUMULATOR -- requirements
Module: sum_accumulator

---
 rtl/sum_accumulator.sv | 112 +++++++++++
 1 files changed

// File: rtl/sum_accumulator.sv
// sum_accumulator: collects unsigned adder sums into windows and presents
// each window total with its sample count and an overflow flag.
// Build option: define SUM_ACCUMULATOR_SATURATE_EN to clamp the total at
// all-ones on overflow; left undefined, the total wraps modulo 2^ACC_WIDTH.
module sum_accumulator #(
  parameter int unsigned WIDTH     = 64,
  parameter int unsigned ACC_WIDTH = 72,
  parameter int unsigned WIN_LEN   = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_data,
  input  logic                 in_last,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [ACC_WIDTH-1:0] out_sum,
  output logic [7:0]           out_count,
  output logic                 out_ovf
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_t;

  localparam logic [7:0] WIN_LEN_C = 8'(WIN_LEN);

  state_t                 state_q, state_d;
  logic [ACC_WIDTH-1:0]   acc_q, acc_d;
  logic [7:0]             count_q, count_d;
  logic                   ovf_q, ovf_d;
  logic                   rdy_q;

  logic                   accept;
  logic [ACC_WIDTH:0]     sum_ext;
  logic                   carry;
  logic [7:0]             count_inc;

  // rdy_q holds in_ready low during reset and releases it on the first edge after.
  assign in_ready  = rdy_q && (state_q != HOLD);
  assign accept    = in_valid && in_ready;
  assign sum_ext   = {1'b0, acc_q} + {{(ACC_WIDTH+1-WIDTH){1'b0}}, in_data};
  assign carry     = sum_ext[ACC_WIDTH];
  assign count_inc = count_q + 8'd1;

  assign out_valid = (state_q == HOLD);
  assign out_sum   = out_valid ? acc_q   : '0;
  assign out_count = out_valid ? count_q : '0;
  assign out_ovf   = out_valid ? ovf_q   : 1'b0;

  // State, accumulator, count and overflow registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      acc_q   <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
      rdy_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
      rdy_q   <= 1'b1;
    end
  end

  // Next-state and datapath update for the window FSM.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    count_d = count_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          acc_d   = {{(ACC_WIDTH-WIDTH){1'b0}}, in_data};
          count_d = 8'd1;
          ovf_d   = 1'b0;
          state_d = (in_last || (WIN_LEN == 1)) ? HOLD : ACCUM;
        end
      end
      ACCUM: begin
        if (accept) begin
          count_d = count_inc;
          if (carry) ovf_d = 1'b1;
`ifdef SUM_ACCUMULATOR_SATURATE_EN
          // Once clamped, the total stays at all-ones for the rest of the window.
          acc_d = (ovf_q || carry) ? '1 : sum_ext[ACC_WIDTH-1:0];
`else
          acc_d = sum_ext[ACC_WIDTH-1:0];
`endif
          // A last flag on the WIN_LEN-th sample is a single close condition.
          if (in_last || (count_inc == WIN_LEN_C)) state_d = HOLD;
        end
      end
      HOLD: begin
        if (out_ready) begin
          state_d = IDLE;
          acc_d   = '0;
          count_d = '0;
          ovf_d   = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule
